// File: rtl/dna_dsp_pkg.sv
// Shared DSP types and defaults for the sample datapath.
// Sample width and window depth used by the averaging stages.
package dna_dsp_pkg;

    localparam int SAMPLE_W = 12;
    localparam int WIN_LOG2 = 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/window_buf.sv
// Circular register file holding the moving-average window.
// One write port; the read port looks at the same pointer.
module window_buf
    import dna_dsp_pkg::*;
#(
    parameter int WIDTH      = SAMPLE_W,
    parameter int LOG2_DEPTH = WIN_LOG2
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [LOG2_DEPTH-1:0]   ptr,
    input  logic signed [WIDTH-1:0] wr_data,
    output logic signed [WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic signed [WIDTH-1:0] mem [DEPTH];

    // Storage is unreset; the fill count decides which entries matter.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= wr_data;
        end
    end

    // The oldest entry sits at the write pointer once the window is full.
    assign rd_data = mem[ptr];

endmodule

// File: rtl/window_avg.sv
// Streaming moving average over the last 2^LOG2_DEPTH samples.
// Rounded mean is registered with a one-cycle valid pulse.
module window_avg
    import dna_dsp_pkg::*;
#(
    parameter int WIDTH      = SAMPLE_W,
    parameter int LOG2_DEPTH = WIN_LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] din,
    input  logic                    flush,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] dout,
    output logic [LOG2_DEPTH:0]     fill
);

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = WIDTH + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;

    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  old_ext;
    logic signed [SUM_W-1:0]  rnd;
    logic [LOG2_DEPTH-1:0]    wr_ptr;
    logic [LOG2_DEPTH-1:0]    ptr_next;
    logic [LOG2_DEPTH-1:0]    buf_ptr;
    logic [FILL_W-1:0]        fill_next;
    logic                     full;
    logic                     ov_next;
    logic signed [WIDTH-1:0]  dout_next;
    logic signed [WIDTH-1:0]  old;

    assign full = (fill == FILL_W'(DEPTH));

    // A flushing write restarts the window at slot 0.
    assign buf_ptr = flush ? '0 : wr_ptr;

    window_buf #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (in_valid),
        .ptr     (buf_ptr),
        .wr_data (din),
        .rd_data (old)
    );

    // Next window state and rounded mean from the post-update sum.
    always_comb begin
        sum_next  = sum;
        fill_next = fill;
        ptr_next  = wr_ptr;
        ov_next   = 1'b0;
        dout_next = dout;
        old_ext   = full ? SUM_W'(old) : '0;
        rnd       = '0;
        if (flush) begin
            if (in_valid) begin
                sum_next  = SUM_W'(din);
                fill_next = FILL_W'(1);
                ptr_next  = LOG2_DEPTH'(1);
            end else begin
                sum_next  = '0;
                fill_next = '0;
                ptr_next  = '0;
            end
        end else if (in_valid) begin
            sum_next  = sum + SUM_W'(din) - old_ext;
            fill_next = full ? fill : fill + FILL_W'(1);
            ptr_next  = wr_ptr + LOG2_DEPTH'(1);
            if (fill_next == FILL_W'(DEPTH)) begin
                rnd       = sum_next + SUM_W'(DEPTH / 2);
                dout_next = WIDTH'(rnd >>> LOG2_DEPTH);
                ov_next   = 1'b1;
            end
        end
    end

    // Window bookkeeping and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            fill      <= '0;
            wr_ptr    <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            sum       <= sum_next;
            fill      <= fill_next;
            wr_ptr    <= ptr_next;
            out_valid <= ov_next;
            dout      <= dout_next;
        end
    end

endmodule

// File: tb/tb_window_avg.sv
// Scoreboard bench for window_avg.
// A reference window queue predicts every registered output.
module tb_window_avg;
    import dna_dsp_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        int ov;
        int dv;
        int fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    sample_t     din = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    sample_t     dout;
    logic [3:0]  fill;

    int n_chk = 0;
    int n_fail = 0;

    int   win[$];
    int   m_dout = 0;
    exp_t sb[$];

    window_avg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din       (din),
        .flush     (flush),
        .out_valid (out_valid),
        .dout      (dout),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic step(input string tag, input bit r, input bit v,
                        input int d, input bit f);
        exp_t e;
        int   s;
        @(negedge clk);
        rst = r;
        in_valid = v;
        din = sample_t'(d);
        flush = f;
        e.ov = 0;
        if (r) begin
            win.delete();
            m_dout = 0;
        end else if (f) begin
            win.delete();
            if (v) win.push_back(d);
        end else if (v) begin
            win.push_back(d);
            if (win.size() > DEPTH) void'(win.pop_front());
            if (win.size() == DEPTH) begin
                s = 0;
                foreach (win[i]) s += win[i];
                m_dout = (s + DEPTH / 2) >>> 3;
                e.ov = 1;
            end
        end
        e.dv = m_dout;
        e.fl = win.size();
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_ov"}, int'(out_valid), e.ov);
            check({tag, "_dout"}, int'(dout), e.dv);
            check({tag, "_fill"}, int'(fill), e.fl);
        end
    endtask

    initial begin
        step("rst0", 1, 1, 100, 0);
        step("rst1", 1, 1, 100, 0);
        step("rel", 0, 0, 100, 0);

        for (int i = 0; i < 8; i++) step("warm", 0, 1, 10, 0);
        step("slide14", 0, 1, 14, 0);
        check("slide14_val", int'(dout), 11);

        for (int i = 0; i < 8; i++) step("refill", 0, 1, 10, 0);
        check("refill_val", int'(dout), 10);
        step("flushv", 0, 1, -7, 1);
        check("flushv_hold", int'(dout), 10);
        for (int i = 0; i < 7; i++) step("neg7", 0, 1, -7, 0);
        check("neg7_val", int'(dout), -7);
        step("flush0", 0, 0, 0, 1);
        check("flush0_fill", int'(fill), 0);

        for (int i = 0; i < 8; i++) step("max", 0, 1, 2047, 0);
        check("max_val", int'(dout), 2047);
        for (int i = 0; i < 8; i++) step("min", 0, 1, -2048, 0);
        check("min_val", int'(dout), -2048);

        for (int i = 0; i < 10; i++) begin
            step("gap_v", 0, 1, 5, 0);
            step("gap_i", 0, 0, 99, 0);
            if (i % 3 == 0) step("gap_i2", 0, 0, -99, 0);
        end
        check("gap_val", int'(dout), 5);

        for (int i = 0; i < 40; i++)
            step("rand", 0, ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 4095) - 2048,
                 ($urandom_range(0, 19) == 0));

        for (int i = 0; i < 8; i++) step("pre", 0, 1, 300 + i, 0);
        step("mrst", 1, 1, 50, 0);
        for (int i = 0; i < 8; i++) step("post", 0, 1, -3 - i, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
